// File: rtl/maze_walker_dp.sv
// Location datapath for the maze walker: holds the current {X,Y} cell, steps it
// through a three-state move handshake, and keeps a backtrack stack.
module maze_walker_dp #(
   parameter int                       COORD_W     = 4,
   parameter int                       STACK_DEPTH = 16,
   parameter logic [2*COORD_W-1:0]     START_LOC   = '0
) (
   input  logic                               clk,
   input  logic                               rst,
   input  logic [1:0]                         i_dir,
   input  logic                               i_move_req,
   input  logic                               i_push,
   input  logic                               i_pop,
   input  logic                               i_restore,
   output logic [2*COORD_W-1:0]               o_cur_loc,
   output logic [2*COORD_W-1:0]               o_nxt_loc,
   output logic                               o_at_edge,
   output logic [2*COORD_W-1:0]               o_stk_top,
   output logic                               o_busy,
   output logic                               o_move_done,
   output logic                               o_move_blk,
   output logic                               o_stk_empty,
   output logic                               o_stk_full,
   output logic [$clog2(STACK_DEPTH):0]       o_stk_cnt,
   output logic                               o_err_ovf,
   output logic                               o_err_unf
);

   localparam int LOC_W = 2 * COORD_W;
   localparam int PTR_W = $clog2(STACK_DEPTH);
   localparam int CNT_W = PTR_W + 1;

   typedef enum logic [1:0] {S_IDLE, S_CALC, S_COMMIT} state_t;

   state_t             r_state;
   state_t             w_state_nxt;
   logic [LOC_W-1:0]   r_cur_loc;
   logic [LOC_W-1:0]   r_temp;
   logic               r_move_done;
   logic               r_move_blk;
   logic [CNT_W-1:0]   r_cnt;
   logic               r_err_ovf;
   logic               r_err_unf;
   logic [LOC_W-1:0]   r_stack [STACK_DEPTH];

   logic [COORD_W-1:0] w_x, w_y, w_coord, w_coord_nxt;
   logic               w_axis_x, w_plus, w_at_edge;
   logic [LOC_W-1:0]   w_nxt_loc, w_stk_top;
   logic               w_idle, w_empty, w_full;
   logic               w_restore_acc, w_restore_pop;
   logic               w_push, w_pop, w_replace, w_do_push, w_do_pop;
   logic               w_push_ovf, w_pop_unf;
   logic               w_move_acc, w_move_blk;
   logic               w_wr_en;
   logic [CNT_W-1:0]   w_cnt_m1;
   logic [PTR_W-1:0]   w_top_idx, w_wr_idx;

   // Direction decode: odd parity selects the X axis, dir[0] selects +1.
   assign w_x         = r_cur_loc[LOC_W-1:COORD_W];
   assign w_y         = r_cur_loc[COORD_W-1:0];
   assign w_axis_x    = ^i_dir;
   assign w_plus      = i_dir[0];
   assign w_coord     = w_axis_x ? w_x : w_y;
   assign w_coord_nxt = w_plus ? (w_coord + COORD_W'(1)) : (w_coord - COORD_W'(1));
   assign w_at_edge   = w_plus ? (w_coord == '1) : (w_coord == '0);
   assign w_nxt_loc   = w_axis_x ? {w_coord_nxt, w_y} : {w_x, w_coord_nxt};

   assign w_idle    = (r_state == S_IDLE);
   assign w_empty   = (r_cnt == '0);
   assign w_full    = (r_cnt == CNT_W'(STACK_DEPTH));
   assign w_cnt_m1  = r_cnt - CNT_W'(1);
   assign w_top_idx = w_cnt_m1[PTR_W-1:0];
   assign w_stk_top = w_empty ? '0 : r_stack[w_top_idx];

   // An accepted restore owns the stack this cycle, so push/pop are masked.
   assign w_restore_acc = w_idle & i_restore;
   assign w_restore_pop = w_restore_acc & ~w_empty;
   assign w_push        = i_push & ~w_restore_acc;
   assign w_pop         = i_pop & ~w_restore_acc;
   assign w_replace     = w_push & w_pop & ~w_empty;
   assign w_do_push     = w_push & ~w_replace & ~w_full;
   assign w_push_ovf    = w_push & ~w_pop & w_full;
   assign w_do_pop      = (w_pop & ~w_push & ~w_empty) | w_restore_pop;
   assign w_pop_unf     = (w_pop & ~w_push & w_empty) | (w_restore_acc & w_empty);
   assign w_wr_en       = w_do_push | w_replace;
   assign w_wr_idx      = w_replace ? w_top_idx : r_cnt[PTR_W-1:0];

   assign w_move_acc = w_idle & i_move_req & ~i_restore & ~w_at_edge;
   assign w_move_blk = w_idle & i_move_req & ~i_restore & w_at_edge;

   always_comb begin
      // NOTE: default first so every path assigns the next state and no latch is inferred.
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:   if (w_move_acc) w_state_nxt = S_CALC;
         S_CALC:   w_state_nxt = S_COMMIT;
         S_COMMIT: w_state_nxt = S_IDLE;
         default:  w_state_nxt = S_IDLE;
      endcase
   end

   // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state     <= S_IDLE;
         r_cur_loc   <= START_LOC;
         r_temp      <= '0;
         r_move_done <= 1'b0;
         r_move_blk  <= 1'b0;
         r_cnt       <= '0;
         r_err_ovf   <= 1'b0;
         r_err_unf   <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_move_done <= (r_state == S_COMMIT);
         r_move_blk  <= w_move_blk;
         if (w_move_acc)
            r_temp <= w_nxt_loc;
         if (r_state == S_COMMIT)
            r_cur_loc <= r_temp;
         else if (w_restore_pop)
            r_cur_loc <= w_stk_top;
         if (w_do_push)
            r_cnt <= r_cnt + CNT_W'(1);
         else if (w_do_pop)
            r_cnt <= w_cnt_m1;
         if (w_push_ovf)
            r_err_ovf <= 1'b1;
         if (w_pop_unf)
            r_err_unf <= 1'b1;
      end
   end

   // NOTE: stack storage has no reset; the count alone defines which entries are valid.
   always_ff @(posedge clk) begin
      if (w_wr_en)
         r_stack[w_wr_idx] <= r_cur_loc;
   end

   assign o_cur_loc   = r_cur_loc;
   assign o_nxt_loc   = w_nxt_loc;
   assign o_at_edge   = w_at_edge;
   assign o_stk_top   = w_stk_top;
   assign o_busy      = ~w_idle;
   assign o_move_done = r_move_done;
   assign o_move_blk  = r_move_blk;
   assign o_stk_empty = w_empty;
   assign o_stk_full  = w_full;
   assign o_stk_cnt   = r_cnt;
   assign o_err_ovf   = r_err_ovf;
   assign o_err_unf   = r_err_unf;

endmodule
